// File: rtl/cover_pkg.sv
// Shared constants and state encoding for the toggle-coverage collector.
package cover_pkg;

    localparam int COVER_TOTAL = 38253;
    localparam int IDX_W       = 16;
    localparam int WORD_W      = 32;
    localparam int NWORDS      = (COVER_TOTAL + WORD_W - 1) / WORD_W;
    localparam int ADDR_W      = $clog2(NWORDS);
    localparam int BIT_W       = $clog2(WORD_W);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        UPDATE = 2'd2
    } state_t;

endpackage

// File: rtl/cover_bitmap_ram.sv
// Hit bitmap storage: one write port, one synchronous read port, no reset.
// The collector never reads and writes the same word in one cycle.
module cover_bitmap_ram
    import cover_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [NWORDS];

    // Registered write and registered read, both gated by their enables
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: deduplicates a stream of cover-point indices
// into a bitmap, counts unique hits and exposes the bitmap by word reads.
//
// state  | meaning
// -------+-------------------------------------------------------------
// CLEAR  | sweep zeros into bitmap word clr_ptr, one word per cycle
// IDLE   | accept clear, read or index (in that priority)
// UPDATE | read word back; set bit, count and pulse if it was clear
module cover_toggle_collector
    import cover_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_index,
    input  logic              clear_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic [IDX_W:0]    hit_count,
    output logic              new_hit,
    output logic              err_oor,
    output logic              busy
);

    localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(COVER_TOTAL - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NWORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] lat_addr;
    logic [BIT_W-1:0]  lat_bit;
    logic [IDX_W:0]    cnt_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [WORD_W-1:0] ram_rdata;

    logic              accept;
    logic              rd_issue;
    logic              oor_hit;
    logic              clear_go;

    cover_bitmap_ram u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus RAM port and handshake control
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        new_hit   = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = clr_ptr;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_raddr = rd_addr;
        accept    = 1'b0;
        rd_issue  = 1'b0;
        oor_hit   = 1'b0;
        clear_go  = 1'b0;

        unique case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_ptr;
                if (clr_ptr == LAST_WORD) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                in_ready = !clear_req && !rd_req;
                if (clear_req) begin
                    clear_go  = 1'b1;
                    state_nxt = CLEAR;
                end else if (rd_req) begin
                    rd_issue  = 1'b1;
                    ram_re    = 1'b1;
                    ram_raddr = rd_addr;
                end else if (in_valid) begin
                    if (in_index > MAX_IDX) begin
                        oor_hit = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        ram_re    = 1'b1;
                        ram_raddr = ADDR_W'(in_index >> BIT_W);
                        state_nxt = UPDATE;
                    end
                end
            end
            UPDATE: begin
                state_nxt = IDLE;
                if (!ram_rdata[lat_bit]) begin
                    ram_we    = 1'b1;
                    ram_waddr = lat_addr;
                    ram_wdata = ram_rdata | (WORD_W'(1) << lat_bit);
                    new_hit   = 1'b1;
                end
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase

        // A reset arriving mid-UPDATE must not commit its write
        if (reset) begin
            ram_we  = 1'b0;
            new_hit = 1'b0;
        end
    end

    // Sweep pointer: walks the bitmap in CLEAR, rewinds on a clear request
    always_ff @(posedge clock) begin
        if (reset || clear_go) begin
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= (clr_ptr == LAST_WORD) ? '0 : clr_ptr + ADDR_W'(1);
        end
    end

    // Word address and bit of the accepted index, used by UPDATE
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_addr <= '0;
            lat_bit  <= '0;
        end else if (accept) begin
            lat_addr <= ADDR_W'(in_index >> BIT_W);
            lat_bit  <= in_index[BIT_W-1:0];
        end
    end

    // Unique-hit counter; zeroed when a clear starts
    always_ff @(posedge clock) begin
        if (reset || clear_go) begin
            cnt_q <= '0;
        end else if (new_hit) begin
            cnt_q <= cnt_q + (IDX_W + 1)'(1);
        end
    end

    // Sticky out-of-range flag, only reset clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            err_oor <= 1'b0;
        end else if (oor_hit) begin
            err_oor <= 1'b1;
        end
    end

    // Read-port valid follows an IDLE read by one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_issue;
        end
    end

    // The count shows the new hit in the same cycle as the pulse
    assign hit_count = cnt_q + {{IDX_W{1'b0}}, new_hit};
    assign rd_data   = rd_valid ? ram_rdata : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector.
module tb_cover_toggle_collector;
    import cover_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IDX_W-1:0]  in_index = '0;
    logic              clear_req = 1'b0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic [IDX_W:0]    hit_count;
    logic              new_hit;
    logic              err_oor;
    logic              busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    cover_toggle_collector dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .clear_req (clear_req),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .hit_count (hit_count),
        .new_hit   (new_hit),
        .err_oor   (err_oor),
        .busy      (busy)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Counts cycles with busy high, starting with the current one.
    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            @(negedge clock);
            #1;
        end
    endtask

    task automatic do_read(input int addr, output logic v, output logic [WORD_W-1:0] d);
        @(negedge clock);
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(addr);
        @(negedge clock);
        rd_req = 1'b0;
        #1;
        v = rd_valid;
        d = rd_data;
    endtask

    // Offers one index, returns new_hit and hit_count in the cycle after accept.
    task automatic send_index(input int idx, output logic hit, output logic [IDX_W:0] cnt);
        int n;
        @(negedge clock);
        in_valid = 1'b1;
        in_index = IDX_W'(idx);
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait idx=%0d: in_ready=%b, required 1 within 50 cycles", idx, in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_index = 16'hA5A5;
        #1;
        hit = new_hit;
        cnt = hit_count;
    endtask

    task automatic do_clear();
        int n;
        @(negedge clock);
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        #1;
        wait_sweep(n);
        checks++;
        if (n !== 1196) begin
            errors++;
            $display("FAIL clear_sweep: busy cycles=%0d, required 1196", n);
        end
    endtask

    task automatic test_reset();
        int n;
        logic v;
        logic [WORD_W-1:0] d;
        int addrs[3] = '{0, 600, 1195};
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({in_ready, rd_valid, new_hit, err_oor, busy} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags: {in_ready,rd_valid,new_hit,err_oor,busy}=%b, required 00001",
                     {in_ready, rd_valid, new_hit, err_oor, busy});
        end
        checks++;
        if (rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h, required 0", rd_data);
        end
        checks++;
        if (hit_count !== '0) begin
            errors++;
            $display("FAIL reset_hit_count: got %0d, required 0", hit_count);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        wait_sweep(n);
        checks++;
        if (n !== 1196) begin
            errors++;
            $display("FAIL startup_busy: busy cycles=%0d, required 1196", n);
        end
        checks++;
        if ({in_ready, hit_count} !== {1'b1, 17'd0}) begin
            errors++;
            $display("FAIL startup_idle: in_ready=%b hit_count=%0d, required 1 and 0", in_ready, hit_count);
        end
        foreach (addrs[i]) begin
            do_read(addrs[i], v, d);
            checks++;
            if ({v, d} !== {1'b1, 32'h0}) begin
                errors++;
                $display("FAIL startup_word%0d: valid=%b data=%h, required 1 and 00000000", addrs[i], v, d);
            end
        end
    endtask

    task automatic test_unique();
        int idxs[4] = '{0, 31, 32, 38252};
        int addrs[3] = '{0, 1, 1195};
        logic [WORD_W-1:0] exp_words[3] = '{32'h8000_0001, 32'h0000_0001, 32'h0000_1000};
        logic hit;
        logic [IDX_W:0] cnt;
        logic v;
        logic [WORD_W-1:0] d;
        int pulses = 0;
        foreach (idxs[i]) begin
            send_index(idxs[i], hit, cnt);
            if (hit === 1'b1) pulses++;
            checks++;
            if (cnt !== (IDX_W + 1)'(i + 1)) begin
                errors++;
                $display("FAIL unique_count idx=%0d: hit_count=%0d, required %0d", idxs[i], cnt, i + 1);
            end
        end
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL unique_pulses: got %0d, required 4", pulses);
        end
        foreach (addrs[i]) begin
            do_read(addrs[i], v, d);
            checks++;
            if ({v, d} !== {1'b1, exp_words[i]}) begin
                errors++;
                $display("FAIL unique_word%0d: valid=%b data=%h, required 1 and %h", addrs[i], v, d, exp_words[i]);
            end
        end
        checks++;
        if (hit_count !== 17'd4) begin
            errors++;
            $display("FAIL unique_final_count: got %0d, required 4", hit_count);
        end
    endtask

    task automatic test_duplicates();
        logic [4:0] pat = '0;
        int hits = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_index = 16'd5;
        for (int i = 0; i < 5; i++) begin
            #1;
            pat = {pat[3:0], in_ready};
            if (new_hit === 1'b1) hits++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        #1;
        if (new_hit === 1'b1) hits++;
        checks++;
        if (pat !== 5'b10101) begin
            errors++;
            $display("FAIL dup_ready_pattern: got %b, required 10101", pat);
        end
        checks++;
        if (hits !== 1) begin
            errors++;
            $display("FAIL dup_pulses: got %0d, required 1", hits);
        end
        @(negedge clock);
        #1;
        checks++;
        if (hit_count !== 17'd1) begin
            errors++;
            $display("FAIL dup_count: got %0d, required 1", hit_count);
        end
    endtask

    task automatic test_oor();
        int idxs[2] = '{38253, 65535};
        logic hit;
        logic [IDX_W:0] cnt;
        logic v;
        logic [WORD_W-1:0] d;
        checks++;
        if (err_oor !== 1'b0) begin
            errors++;
            $display("FAIL oor_initial: err_oor=%b, required 0", err_oor);
        end
        foreach (idxs[i]) begin
            send_index(idxs[i], hit, cnt);
            checks++;
            if ({hit, cnt} !== {1'b0, 17'd1}) begin
                errors++;
                $display("FAIL oor_idx%0d: new_hit=%b hit_count=%0d, required 0 and 1", idxs[i], hit, cnt);
            end
        end
        checks++;
        if (err_oor !== 1'b1) begin
            errors++;
            $display("FAIL oor_flag: err_oor=%b, required 1", err_oor);
        end
        do_read(1195, v, d);
        checks++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL oor_no_write: valid=%b word1195=%h, required 1 and 00000000", v, d);
        end
        do_clear();
        checks++;
        if ({err_oor, hit_count} !== {1'b1, 17'd0}) begin
            errors++;
            $display("FAIL oor_sticky: err_oor=%b hit_count=%0d, required 1 and 0", err_oor, hit_count);
        end
    endtask

    task automatic test_clear_priority();
        logic hit;
        logic [IDX_W:0] cnt;
        logic v;
        logic [WORD_W-1:0] d;
        int n;
        int addrs[4] = '{0, 3, 600, 1195};
        for (int i = 0; i < 10; i++) begin
            send_index(100 + i, hit, cnt);
        end
        checks++;
        if (cnt !== 17'd10) begin
            errors++;
            $display("FAIL prio_precount: hit_count=%0d, required 10", cnt);
        end
        @(negedge clock);
        clear_req = 1'b1;
        in_valid  = 1'b1;
        in_index  = 16'd200;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_ready: in_ready=%b, required 0", in_ready);
        end
        @(negedge clock);
        clear_req = 1'b0;
        #1;
        checks++;
        if ({busy, in_ready, new_hit, hit_count} !== {3'b100, 17'd0}) begin
            errors++;
            $display("FAIL prio_clear_entry: busy=%b in_ready=%b new_hit=%b hit_count=%0d, required 1 0 0 0",
                     busy, in_ready, new_hit, hit_count);
        end
        wait_sweep(n);
        in_valid = 1'b0;
        checks++;
        if (n !== 1196) begin
            errors++;
            $display("FAIL prio_sweep: busy cycles=%0d, required 1196", n);
        end
        foreach (addrs[i]) begin
            do_read(addrs[i], v, d);
            checks++;
            if ({v, d} !== {1'b1, 32'h0}) begin
                errors++;
                $display("FAIL prio_word%0d: valid=%b data=%h, required 1 and 00000000", addrs[i], v, d);
            end
        end
        checks++;
        if (hit_count !== 17'd0) begin
            errors++;
            $display("FAIL prio_final_count: got %0d, required 0", hit_count);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic hit;
        logic [IDX_W:0] cnt;
        logic v;
        logic [WORD_W-1:0] d;
        int n;
        send_index(7, hit, cnt);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (500) @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy: busy=%b at sweep cycle 500, required 1", busy);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        wait_sweep(n);
        checks++;
        if (n !== 1196) begin
            errors++;
            $display("FAIL restart_sweep: busy cycles=%0d, required 1196", n);
        end
        checks++;
        if ({err_oor, in_ready, hit_count} !== {2'b01, 17'd0}) begin
            errors++;
            $display("FAIL restart_state: err_oor=%b in_ready=%b hit_count=%0d, required 0 1 0",
                     err_oor, in_ready, hit_count);
        end
        do_read(0, v, d);
        checks++;
        if ({v, d} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL restart_word0: valid=%b data=%h, required 1 and 00000000", v, d);
        end
    endtask

    initial begin
        test_reset();
        test_unique();
        do_clear();
        test_duplicates();
        test_oor();
        test_clear_priority();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cover_toggle_collector.md
# cover_toggle_collector

Hardware receiver for toggle-coverage events. It consumes a stream of cover-point indices, the same index space that the per-signal toggle reporters emit through `v_cover_toggle`. It keeps a deduplicated hit bitmap and a unique-hit counter, and exposes the bitmap through a word-read port. It sits between the coverage reporters, serialized into an index stream, and the host/formal harness, so that coverage is available without DPI.

## Interface
Parameters:
- `COVER_TOTAL`, 38253: number of cover points; valid indices are 0..COVER_TOTAL-1.
- `IDX_W`, 16: index width, equal to $clog2(COVER_TOTAL).
- `WORD_W`, 32: bitmap word width.
- `NWORDS`, ceil(COVER_TOTAL/WORD_W) = 1196: bitmap depth.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  cover index offered.
- `in_ready`  out  1  collector can accept an index.
- `in_index`  in  IDX_W  cover index.
- `clear_req`  in  1  request a bitmap and counter wipe.
- `rd_req`  in  1  bitmap word read request.
- `rd_addr`  in  $clog2(NWORDS)  word address.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `rd_data`  out  WORD_W  bitmap word; bit b holds index addr*WORD_W+b.
- `hit_count`  out  IDX_W+1  number of distinct indices hit.
- `new_hit`  out  1  one-cycle pulse when an index is set for the first time.
- `err_oor`  out  1  sticky flag; an out-of-range index was received.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine has three states: CLEAR, IDLE and UPDATE.
- CLEAR:
  - Writes zero to word `clr_ptr`, one word per cycle, for `clr_ptr` = 0..NWORDS-1.
  - After the last word, goes to IDLE.
  - `hit_count` is forced to 0 on entry.
  - `in_ready` is 0 throughout.
  - `rd_req` is ignored.
- IDLE: `in_ready` = !clear_req && !rd_req. Priority order is:
  - `clear_req` has highest priority: go to CLEAR with `clr_ptr` = 0.
  - else `rd_req`: issue a RAM read of `rd_addr`. `rd_valid` is 1 on the next cycle with the word. Stay in IDLE.
  - else `in_valid` && `in_ready` (accept):
    - If `in_index` >= COVER_TOTAL: set `err_oor`, make no RAM access, stay in IDLE.
    - Else: latch the word address (`in_index`/WORD_W) and bit (`in_index`%WORD_W), issue a RAM read, go to UPDATE.
- UPDATE (one cycle; `in_ready` = 0):
  - If the read bit is 0: write word | (1<<bit), increment `hit_count`, pulse `new_hit` this cycle.
  - If the read bit is already 1: no write, no count, no pulse.
  - Always return to IDLE.
- Reads use the latched index only; `in_index` may change after the handshake.
- `hit_count` never exceeds COVER_TOTAL, so it needs no saturation.
- `err_oor` is cleared only by `reset`; `clear_req` does not clear it.

## Timing
- Reset values: `in_ready` 0, `rd_valid` 0, `rd_data` 0, `hit_count` 0, `new_hit` 0, `err_oor` 0, `busy` 1. State is CLEAR with `clr_ptr` 0.
- Reset start-up sweep:
  - The RAM has no reset, so the sweep is mandatory.
  - First cycle after `reset` deasserts clears word 0.
  - IDLE is entered after NWORDS = 1196 cycles.
  - `in_ready` rises on cycle 1196 after deassert.
- Index handling:
  - Accept at cycle t; `new_hit` and the `hit_count` update are visible at t+1.
  - The RAM write commits at the end of t+1.
  - `in_ready` is back to 1 at t+2.
  - Sustained throughput is one index per 2 cycles.
- Back-to-back same word: no forwarding is needed. The write at t+1 completes before the next read at t+2, so a duplicate index sent right after its first occurrence does not pulse `new_hit`.
- Read port: `rd_req` at t gives `rd_valid` and `rd_data` at t+1. A read issued the cycle after an UPDATE returns the updated word.
- `reset` mid-CLEAR or mid-UPDATE: a pending write is dropped and the sweep restarts from word 0.
- `clear_req` while in UPDATE: UPDATE finishes first, and the request is honoured in IDLE if `clear_req` is still high. The requester holds `clear_req` until `busy` rises.
- Last word: only bits 0..(COVER_TOTAL-1)%WORD_W = 12 are ever set; bits 13..31 read 0.

## Structure
- Package `cover_pkg`:
  - constants COVER_TOTAL, IDX_W, WORD_W, NWORDS, ADDR_W;
  - state enum {CLEAR, IDLE, UPDATE}.
- Sub-module `cover_bitmap_ram`: 1R1W, synchronous read, NWORDS x WORD_W, no reset. Read and write in the same cycle to different addresses only; the FSM never issues a same-address read and write together.
- The top level holds the FSM, `clr_ptr`, the latched address and bit, the counter and the flags.

## Test plan
- Start-up: deassert `reset` → `busy`=1 for 1196 cycles. Then `in_ready`=1, `hit_count`=0, and reads of words 0, 600 and 1195 all return 0.
- Unique hits: send indices 0, 31, 32, 38252 → 4 `new_hit` pulses and `hit_count`=4. Word 0 = 0x8000_0001, word 1 = 0x0000_0001, word 1195 = 0x0000_1000.
- Duplicates: send 5, 5, 5 back-to-back → one `new_hit` pulse and `hit_count`=1. `in_ready` toggles 1,0,1,0,1.
- Out of range: send 38253 and 65535 → `err_oor`=1, `hit_count` unchanged, no RAM write. After `clear_req`, `err_oor` is still 1.
- Clear and priority: hit 10 indices, then assert `clear_req` and `in_valid` together → CLEAR taken, `in_ready`=0, `hit_count`=0 after entry, and all words read 0 after 1196 cycles.
- Reset mid-sweep: assert `reset` at sweep cycle 500 → the sweep restarts at word 0, and the full 1196-cycle `busy` period is observed.
